countdown_ctrl: RTL

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown timer controller.
// Counts down on 1 Hz ticks, supports digit editing, pause/resume and a timed alarm.
// All outputs come straight from flops, so any input pulse shows up one clock later.
module countdown_ctrl #(
    parameter int unsigned PRESET_H   = 6,
    parameter int unsigned PRESET_L   = 0,
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       set,
    input  logic       inc,
    output logic [3:0] TimeH,
    output logic [3:0] TimeL,
    output logic       beep,
    output logic       sel,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_e;

    localparam logic [3:0] PRE_H    = 4'(PRESET_H);
    localparam logic [3:0] PRE_L    = 4'(PRESET_L);
    localparam logic [3:0] BEEP_CNT = 4'(BEEP_TICKS);

    state_e     state_q,    state_d;
    logic [3:0] time_h_q,   time_h_d;
    logic [3:0] time_l_q,   time_l_d;
    logic       sel_q,      sel_d;
    logic       beep_q,     beep_d;
    logic [3:0] beep_cnt_q, beep_cnt_d;

    logic [3:0] dec_h_s;
    logic [3:0] dec_l_s;
    logic       dec_zero_s;

    // Single BCD digit increment with 9 wrapping to 0 (no carry out).
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd9) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Precompute the two-digit BCD decrement and whether it lands on 00.
    always_comb begin
        dec_h_s = time_h_q;
        dec_l_s = time_l_q;
        if (time_l_q != 4'd0) begin
            dec_l_s = time_l_q - 4'd1;
        end else begin
            dec_l_s = 4'd9;
            dec_h_s = time_h_q - 4'd1;
        end
        dec_zero_s = (dec_h_s == 4'd0) && (dec_l_s == 4'd0);
    end

    // Next-state and next-output logic for the timer FSM.
    always_comb begin
        state_d    = state_q;
        time_h_d   = time_h_q;
        time_l_d   = time_l_q;
        sel_d      = sel_q;
        beep_cnt_d = beep_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A zero time cannot be run; start is then a no-op.
                if (start && ((time_h_q != 4'd0) || (time_l_q != 4'd0))) begin
                    state_d = ST_RUN;
                end else if (set) begin
                    state_d = ST_SET;
                    sel_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SET: begin
                // Increment acts on the digit selected before this cycle's set.
                if (inc) begin
                    if (sel_q) begin
                        time_h_d = bcd_inc(time_h_q);
                    end else begin
                        time_l_d = bcd_inc(time_l_q);
                    end
                end else begin
                    time_h_d = time_h_q;
                end
                if (set) begin
                    if (!sel_q) begin
                        sel_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        sel_d   = 1'b0;
                    end
                end else begin
                    sel_d = sel_q;
                end
            end
            ST_RUN: begin
                // Reaching 00 on a tick beats a simultaneous pause request.
                if (tick) begin
                    time_h_d = dec_h_s;
                    time_l_d = dec_l_s;
                    if (dec_zero_s) begin
                        state_d    = ST_ALARM;
                        beep_cnt_d = BEEP_CNT;
                    end else if (start) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (start) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                // Abort takes priority over resume.
                if (set) begin
                    state_d  = ST_IDLE;
                    time_h_d = PRE_H;
                    time_l_d = PRE_L;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_ALARM: begin
                if (start || set) begin
                    state_d    = ST_IDLE;
                    time_h_d   = PRE_H;
                    time_l_d   = PRE_L;
                    beep_cnt_d = 4'd0;
                end else if (tick) begin
                    beep_cnt_d = beep_cnt_q - 4'd1;
                    if (beep_cnt_q == 4'd1) begin
                        state_d  = ST_IDLE;
                        time_h_d = PRE_H;
                        time_l_d = PRE_L;
                    end else begin
                        state_d = ST_ALARM;
                    end
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: begin
                // Illegal encodings recover to a clean idle state.
                state_d    = ST_IDLE;
                time_h_d   = PRE_H;
                time_l_d   = PRE_L;
                sel_d      = 1'b0;
                beep_cnt_d = 4'd0;
            end
        endcase
        beep_d = (state_d == ST_ALARM);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            time_h_q   <= PRE_H;
            time_l_q   <= PRE_L;
            sel_q      <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            time_h_q   <= time_h_d;
            time_l_q   <= time_l_d;
            sel_q      <= sel_d;
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign TimeH = time_h_q;
    assign TimeL = time_l_q;
    assign beep  = beep_q;
    assign sel   = sel_q;
    assign state = state_q;

endmodule
